mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, memory data width; DATA_W/8 byte-enable bits.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_rd_i  in  1  instruction read request, level, held until instr_ready_o
- instr_addr_i  in  ADDR_W  instruction address
- instr_rdata_o  out  DATA_W  instruction read data, valid while instr_done
- instr_ready_o  out  1  instruction port ready / completion
- data_rd_i  in  1  data read request, level
- data_wr_i  in  1  data write request, level
- data_addr_i  in  ADDR_W  data address
- data_wdata_i  in  DATA_W  write data
- data_be_i  in  DATA_W/8  write byte enables
- data_rdata_o  out  DATA_W  data read data, valid while data_done
- data_ready_o  out  1  data port ready / completion
- mem_req_o  out  1  memory request, held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_be_o  out  DATA_W/8  memory byte enables
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, one cycle

Function
REQ-004 The block SHALL implement FSM states IDLE, INSTR_BUSY, DATA_BUSY, DONE.
REQ-005 IDLE: on a pending request, the block SHALL grant one port, register its address, write data, byte enables and we, and enter the matching BUSY state.
REQ-006 Both ports pending in IDLE: without the macro the block SHALL grant data; with it, per REQ-017.
REQ-007 BUSY: the block SHALL hold mem_req_o=1 with stable registered fields until mem_ack_i, then capture mem_rdata_i into the granted port's rdata register and enter DONE.
REQ-008 DONE: the block SHALL assert the granted port's done for exactly one cycle, then return to IDLE; minimum latency is request to ready in 3 cycles with mem_ack_i in the first BUSY cycle.
REQ-009 instr_ready_o SHALL equal (!instr_rd_i || instr_done); data_ready_o SHALL equal (!(data_rd_i||data_wr_i) || data_done); both are high when no request is pending.
REQ-010 A level request still high in the cycle after its ready pulse SHALL be treated as a new transaction.
REQ-011 A request withdrawn during BUSY SHALL not abort the memory transaction; the result is discarded and no done pulse is produced for it.
REQ-012 data_rd_i and data_wr_i both high SHALL be a write; the write does not update data_rdata_o.
REQ-013 rdata outputs SHALL hold their last captured value until the next completion on that port.
REQ-014 mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o SHALL be 0 whenever mem_req_o is 0.

Reset
REQ-015 Asserting rst_i low SHALL immediately, regardless of clk_i, force state IDLE, mem_req_o=0, all mem_* outputs 0, rdata registers 0, and done flags 0.
REQ-016 Reset asserted mid-transaction SHALL drop mem_req_o at once; a mem_ack_i arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-017 With ARB_ROUND_ROBIN_EN defined, the block SHALL keep a one-bit last-grant register (reset: instr) and, on simultaneous requests, grant the port not granted last; without the macro, data SHALL always win and the register SHALL not exist.

Structure
REQ-018 The block SHALL take its FSM state encoding (2-bit) and default ADDR_W/DATA_W constants from shared package mero_bus_pkg.
REQ-019 The block SHALL be a single module with no sub-module instantiated.

Verification
REQ-020 The bench SHALL check: after reset, instr_rd_i=1 at 0x0000_0010 with mem_ack_i one cycle after mem_req_o and mem_rdata_i=0xDEAD_BEEF -> instr_ready_o pulses once with instr_rdata_o=0xDEAD_BEEF.
REQ-021 The bench SHALL check: simultaneous instr read 0x100 and data write 0x200, wdata 0x1234_5678, be 0xF -> data granted first (mem_we_o=1, addr 0x200); instr next; with ARB_ROUND_ROBIN_EN the second simultaneous pair is granted instr first.
REQ-022 The bench SHALL check: mem_ack_i delayed 5 cycles -> mem_req_o and mem_addr_o stable for all 6 cycles, ready low throughout.
REQ-023 The bench SHALL check: data_rd_i withdrawn during DATA_BUSY -> transaction completes, no data_ready_o pulse, data_rdata_o unchanged.
REQ-024 The bench SHALL check: rst_i driven low between clock edges during INSTR_BUSY -> mem_req_o=0 before the next edge; a subsequent stray mem_ack_i is ignored.

Source files
------------

// File: rtl/mero_bus_pkg.sv
// rtl/mero_bus_pkg.sv - shared FSM encoding and default widths for the memory bus arbiter
package mero_bus_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_INSTR_BUSY = 2'd1;
    localparam logic [1:0] ST_DATA_BUSY  = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - instruction/data port arbiter onto one memory bus (macro ARB_ROUND_ROBIN_EN: alternate grant on contention)
module mem_bus_arbiter
    import mero_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_rd_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic [DATA_W-1:0]   instr_rdata_o,
    output logic                instr_ready_o,
    input  logic                data_rd_i,
    input  logic                data_wr_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_ready_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ack_i
);

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic                we_q;
    logic [DATA_W-1:0]   instr_rdata_q;
    logic [DATA_W-1:0]   data_rdata_q;
    logic                instr_done_q;
    logic                data_done_q;
    // Set once the granted port drops its request; the bus cycle still finishes but its result is dropped.
    logic                abandon_q;

    logic instr_pend;
    logic data_pend;
    logic in_busy;
    logic busy_pend;
    logic grant_data;

    assign instr_pend = instr_rd_i;
    assign data_pend  = data_rd_i | data_wr_i;
    assign in_busy    = (state_q == ST_INSTR_BUSY) || (state_q == ST_DATA_BUSY);
    assign busy_pend  = (state_q == ST_INSTR_BUSY) ? instr_pend : data_pend;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when the data port received the most recent grant.
    logic last_grant_q;
    assign grant_data = data_pend && (!instr_pend || !last_grant_q);
`else
    assign grant_data = data_pend;
`endif

    // Next-state logic: grant from IDLE, wait for ack in BUSY, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    state_d = ST_DATA_BUSY;
                end else if (instr_pend) begin
                    state_d = ST_INSTR_BUSY;
                end
            end
            ST_INSTR_BUSY,
            ST_DATA_BUSY: begin
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, captured request fields, read data and single-cycle done flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            we_q          <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
            instr_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
            abandon_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            instr_done_q <= 1'b0;
            data_done_q  <= 1'b0;
            if (state_q == ST_IDLE) begin
                abandon_q <= 1'b0;
                if (grant_data) begin
                    addr_q  <= data_addr_i;
                    wdata_q <= data_wdata_i;
                    be_q    <= data_be_i;
                    we_q    <= data_wr_i;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_q <= 1'b1;
`endif
                end else if (instr_pend) begin
                    addr_q  <= instr_addr_i;
                    wdata_q <= '0;
                    be_q    <= '0;
                    we_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_q <= 1'b0;
`endif
                end
            end else if (in_busy) begin
                if (!busy_pend) begin
                    abandon_q <= 1'b1;
                end
                if (mem_ack_i && busy_pend && !abandon_q) begin
                    if (state_q == ST_INSTR_BUSY) begin
                        instr_rdata_q <= mem_rdata_i;
                        instr_done_q  <= 1'b1;
                    end else begin
                        data_done_q <= 1'b1;
                        if (!we_q) begin
                            data_rdata_q <= mem_rdata_i;
                        end
                    end
                end
            end
        end
    end

    assign mem_req_o   = in_busy;
    assign mem_we_o    = in_busy & we_q;
    assign mem_addr_o  = in_busy ? addr_q  : '0;
    assign mem_wdata_o = in_busy ? wdata_q : '0;
    assign mem_be_o    = in_busy ? be_q    : '0;

    assign instr_rdata_o = instr_rdata_q;
    assign data_rdata_o  = data_rdata_q;
    assign instr_ready_o = !instr_pend || instr_done_q;
    assign data_ready_o  = !data_pend  || data_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        instr_rd_i = 1'b0;
    logic [31:0] instr_addr_i = 32'h0;
    logic [31:0] instr_rdata_o;
    logic        instr_ready_o;
    logic        data_rd_i = 1'b0;
    logic        data_wr_i = 1'b0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        mem_ack_i = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_rd_i   (instr_rd_i),
        .instr_addr_i (instr_addr_i),
        .instr_rdata_o(instr_rdata_o),
        .instr_ready_o(instr_ready_o),
        .data_rd_i    (data_rd_i),
        .data_wr_i    (data_wr_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_be_i    (data_be_i),
        .data_rdata_o (data_rdata_o),
        .data_ready_o (data_ready_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    initial begin
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of the first BUSY cycle; acks after 'delay' extra cycles, returns in the DONE cycle.
    task automatic serve(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                         input int delay, input logic [31:0] rdata, input logic [1:0] exp_rdy);
        for (int i = 0; i <= delay; i++) begin
            chk({tag, ".req"},   mem_req_o,   1'b1);
            chk({tag, ".we"},    mem_we_o,    exp_we);
            chk({tag, ".addr"},  mem_addr_o,  exp_addr);
            chk({tag, ".wdata"}, mem_wdata_o, exp_wdata);
            chk({tag, ".be"},    mem_be_o,    exp_be);
            chk({tag, ".rdy"},   {instr_ready_o, data_ready_o}, exp_rdy);
            if (i == delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rdata;
            end
            @(negedge clk_i);
        end
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
    endtask

    initial begin
        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst.req",    mem_req_o,     1'b0);
        chk("rst.addr",   mem_addr_o,    32'h0);
        chk("rst.we",     mem_we_o,      1'b0);
        chk("rst.irdy",   instr_ready_o, 1'b1);
        chk("rst.drdy",   data_ready_o,  1'b1);
        chk("rst.irdata", instr_rdata_o, 32'h0);
        chk("rst.drdata", data_rdata_o,  32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Instruction read, ack one cycle after request rises
        instr_rd_i   = 1'b1;
        instr_addr_i = 32'h0000_0010;
        #1;
        chk("i1.rdy_lo", instr_ready_o, 1'b0);
        @(negedge clk_i);
        serve("i1", 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 2'b01);
        chk("i1.rdy_pulse", instr_ready_o, 1'b1);
        chk("i1.rdata",     instr_rdata_o, 32'hDEAD_BEEF);
        chk("i1.req_done",  mem_req_o,     1'b0);
        instr_rd_i = 1'b0;
        @(negedge clk_i);
        chk("i1.idle_req",  mem_req_o,     1'b0);
        chk("i1.hold",      instr_rdata_o, 32'hDEAD_BEEF);

        // Simultaneous requests; data asserts rd+wr together, which must be a write
        instr_rd_i   = 1'b1;
        instr_addr_i = 32'h0000_0100;
        data_rd_i    = 1'b1;
        data_wr_i    = 1'b1;
        data_addr_i  = 32'h0000_0200;
        data_wdata_i = 32'h1234_5678;
        data_be_i    = 4'hF;
        @(negedge clk_i);
        serve("arb.d1", 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 0, 32'hAAAA_5555, 2'b00);
        chk("arb.d1.drdy",  data_ready_o,  1'b1);
        chk("arb.d1.irdy",  instr_ready_o, 1'b0);
        chk("arb.d1.wr_norddata", data_rdata_o, 32'h0);
        @(negedge clk_i);
        chk("arb.newtxn.drdy", data_ready_o, 1'b0);
        chk("arb.idle.req",    mem_req_o,    1'b0);
        @(negedge clk_i);
`ifdef ARB_ROUND_ROBIN_EN
        serve("arb.i2", 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 2'b00);
        chk("arb.i2.irdy",  instr_ready_o, 1'b1);
        chk("arb.i2.rdata", instr_rdata_o, 32'hCAFE_F00D);
        instr_rd_i = 1'b0;
        @(negedge clk_i);
        chk("arb.idle2.we",   mem_we_o,   1'b0);
        chk("arb.idle2.addr", mem_addr_o, 32'h0);
        @(negedge clk_i);
        serve("arb.d3", 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 0, 32'h0, 2'b10);
        chk("arb.d3.drdy", data_ready_o, 1'b1);
        data_rd_i = 1'b0;
        data_wr_i = 1'b0;
`else
        serve("arb.d2", 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 0, 32'h0, 2'b00);
        chk("arb.d2.drdy", data_ready_o, 1'b1);
        data_rd_i = 1'b0;
        data_wr_i = 1'b0;
        @(negedge clk_i);
        chk("arb.idle2.we",   mem_we_o,   1'b0);
        chk("arb.idle2.addr", mem_addr_o, 32'h0);
        chk("arb.idle2.be",   mem_be_o,   4'h0);
        @(negedge clk_i);
        serve("arb.i3", 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 2'b01);
        chk("arb.i3.irdy",  instr_ready_o, 1'b1);
        chk("arb.i3.rdata", instr_rdata_o, 32'hCAFE_F00D);
        instr_rd_i = 1'b0;
`endif
        data_wdata_i = 32'h0;
        data_be_i    = 4'h0;
        @(negedge clk_i);
        chk("arb.end.req", mem_req_o, 1'b0);

        // Data read with ack delayed by five cycles
        data_rd_i   = 1'b1;
        data_addr_i = 32'h0000_0300;
        @(negedge clk_i);
        serve("dly", 1'b0, 32'h0000_0300, 32'h0, 4'h0, 5, 32'h0BAD_F00D, 2'b10);
        chk("dly.drdy",  data_ready_o, 1'b1);
        chk("dly.rdata", data_rdata_o, 32'h0BAD_F00D);
        data_rd_i = 1'b0;
        @(negedge clk_i);

        // Data read withdrawn while busy: bus cycle completes, result dropped
        data_rd_i   = 1'b1;
        data_addr_i = 32'h0000_0400;
        @(negedge clk_i);
        chk("wd.req", mem_req_o, 1'b1);
        data_rd_i = 1'b0;
        @(negedge clk_i);
        chk("wd.req_held", mem_req_o,  1'b1);
        chk("wd.addr",     mem_addr_o, 32'h0000_0400);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_AAAA;
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        chk("wd.req_done", mem_req_o,    1'b0);
        chk("wd.rdata",    data_rdata_o, 32'h0BAD_F00D);
        data_rd_i   = 1'b1;
        data_addr_i = 32'h0000_0500;
        #1;
        chk("wd.no_pulse", data_ready_o, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        serve("wd.next", 1'b0, 32'h0000_0500, 32'h0, 4'h0, 0, 32'h1111_2222, 2'b10);
        chk("wd.next.drdy",  data_ready_o, 1'b1);
        chk("wd.next.rdata", data_rdata_o, 32'h1111_2222);
        data_rd_i = 1'b0;
        @(negedge clk_i);

        // Asynchronous reset during an instruction transaction, then a stray ack
        instr_rd_i   = 1'b1;
        instr_addr_i = 32'h0000_0600;
        @(negedge clk_i);
        chk("ar.req", mem_req_o, 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("ar.req_drop",  mem_req_o,     1'b0);
        chk("ar.addr_drop", mem_addr_o,    32'h0);
        chk("ar.rdata_clr", instr_rdata_o, 32'h0);
        instr_rd_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h9999_9999;
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'h0;
        chk("ar.stray.req",   mem_req_o,     1'b0);
        chk("ar.stray.irdy",  instr_ready_o, 1'b1);
        chk("ar.stray.rdata", instr_rdata_o, 32'h0);
        @(negedge clk_i);
        chk("ar.stray.req2",  mem_req_o,     1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
